// File: rtl/warmboot_sequencer.sv
// Sequences SB_WARMBOOT: claims the shared SPI flash bus, wakes the flash with 0xAB,
// waits tRES, then pulses BOOT with the latched image select.
module warmboot_sequencer #(
  parameter int         SPI_DIV       = 4,
  parameter int         TRES_CYCLES   = 288,
  parameter int         BOOT_HOLD     = 16,
  parameter logic [1:0] DEFAULT_IMAGE = 2'b01
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       boot_req,
  input  logic [1:0] boot_image,
  input  logic       spi_busy,
  output logic       spi_grant,
  output logic       seq_sck,
  output logic       seq_so,
  output logic       seq_ss,
  output logic       wb_boot,
  output logic       wb_s1,
  output logic       wb_s0,
  output logic       busy
);

  localparam int MAX_AB = (SPI_DIV > TRES_CYCLES) ? SPI_DIV : TRES_CYCLES;
  localparam int MAX_C  = (MAX_AB > BOOT_HOLD) ? MAX_AB : BOOT_HOLD;
  localparam int CW     = (MAX_C > 1) ? $clog2(MAX_C) : 1;
  localparam logic [7:0] CMD_RES = 8'hAB;

  typedef enum logic [2:0] {
    S_IDLE, S_WAIT_BUS, S_CMD, S_TRES, S_BOOT, S_HALT
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    bit_q, bit_d;
  logic [6:0]    sh_q, sh_d;
  logic [1:0]    image_q, image_d;
  logic          grant_q, grant_d;
  logic          sck_q, sck_d;
  logic          so_q, so_d;
  logic          ss_q, ss_d;
  logic          wb_boot_q, wb_boot_d;
  logic          busy_q, busy_d;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    bit_d     = bit_q;
    sh_d      = sh_q;
    image_d   = image_q;
    grant_d   = grant_q;
    sck_d     = sck_q;
    so_d      = so_q;
    ss_d      = ss_q;
    wb_boot_d = wb_boot_q;
    busy_d    = busy_q;
    case (state_q)
      S_IDLE: begin
        if (boot_req) begin
          image_d = boot_image;
          busy_d  = 1'b1;
          state_d = S_WAIT_BUS;
        end
      end
      S_WAIT_BUS: begin
        // Never pre-empt the bootloader; take the bus only between its transactions.
        if (!spi_busy) begin
          grant_d = 1'b1;
          ss_d    = 1'b0;
          sck_d   = 1'b0;
          so_d    = CMD_RES[7];
          sh_d    = CMD_RES[6:0];
          cnt_d   = '0;
          bit_d   = '0;
          state_d = S_CMD;
        end
      end
      S_CMD: begin
        if (cnt_q == CW'(SPI_DIV - 1)) begin
          cnt_d = '0;
          if (!sck_q) begin
            sck_d = 1'b1;
          end else if (bit_q == 3'd7) begin
            sck_d   = 1'b0;
            so_d    = 1'b0;
            ss_d    = 1'b1;
            bit_d   = '0;
            state_d = S_TRES;
          end else begin
            sck_d = 1'b0;
            bit_d = bit_q + 3'd1;
            so_d  = sh_q[6];
            sh_d  = {sh_q[5:0], 1'b0};
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_TRES: begin
        if (cnt_q == CW'(TRES_CYCLES - 1)) begin
          cnt_d     = '0;
          wb_boot_d = 1'b1;
          state_d   = S_BOOT;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_BOOT: begin
        if (cnt_q == CW'(BOOT_HOLD - 1)) begin
          cnt_d     = '0;
          wb_boot_d = 1'b0;
          state_d   = S_HALT;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_HALT: ;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      bit_q     <= '0;
      sh_q      <= '0;
      image_q   <= DEFAULT_IMAGE;
      grant_q   <= 1'b0;
      sck_q     <= 1'b0;
      so_q      <= 1'b0;
      ss_q      <= 1'b1;
      wb_boot_q <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bit_q     <= bit_d;
      sh_q      <= sh_d;
      image_q   <= image_d;
      grant_q   <= grant_d;
      sck_q     <= sck_d;
      so_q      <= so_d;
      ss_q      <= ss_d;
      wb_boot_q <= wb_boot_d;
      busy_q    <= busy_d;
    end
  end

  assign spi_grant = grant_q;
  assign seq_sck   = sck_q;
  assign seq_so    = so_q;
  assign seq_ss    = ss_q;
  assign wb_boot   = wb_boot_q;
  assign wb_s1     = image_q[1];
  assign wb_s0     = image_q[0];
  assign busy      = busy_q;

endmodule

// File: tb/tb_warmboot_sequencer.sv
// Directed bench: u0 uses SPI_DIV=2/TRES=10/HOLD=4, u1 uses 1/1/1.
module tb_warmboot_sequencer;

  logic       clk = 1'b0;
  logic       rst0 = 1'b0, rst1 = 1'b0;
  logic       boot_req = 1'b0;
  logic [1:0] boot_image = 2'b00;
  logic       spi_busy = 1'b0;
  logic [1:0] grant, sck, so, ss, wbb, s1, s0, bsy;
  int         sel = 0;
  int         n_vec = 0, n_err = 0;

  always #5 clk = ~clk;

  warmboot_sequencer #(.SPI_DIV(2), .TRES_CYCLES(10), .BOOT_HOLD(4), .DEFAULT_IMAGE(2'b01)) u0 (
    .clk(clk), .resetn(rst0), .boot_req(boot_req), .boot_image(boot_image), .spi_busy(spi_busy),
    .spi_grant(grant[0]), .seq_sck(sck[0]), .seq_so(so[0]), .seq_ss(ss[0]),
    .wb_boot(wbb[0]), .wb_s1(s1[0]), .wb_s0(s0[0]), .busy(bsy[0]));

  warmboot_sequencer #(.SPI_DIV(1), .TRES_CYCLES(1), .BOOT_HOLD(1), .DEFAULT_IMAGE(2'b01)) u1 (
    .clk(clk), .resetn(rst1), .boot_req(boot_req), .boot_image(boot_image), .spi_busy(spi_busy),
    .spi_grant(grant[1]), .seq_sck(sck[1]), .seq_so(so[1]), .seq_ss(ss[1]),
    .wb_boot(wbb[1]), .wb_s1(s1[1]), .wb_s0(s0[1]), .busy(bsy[1]));

  // Outputs of the instance currently under test
  logic m_grant, m_sck, m_so, m_ss, m_wbb, m_bsy;
  logic [1:0] m_img;
  assign m_grant = grant[sel];
  assign m_sck   = sck[sel];
  assign m_so    = so[sel];
  assign m_ss    = ss[sel];
  assign m_wbb   = wbb[sel];
  assign m_bsy   = bsy[sel];
  assign m_img   = {s1[sel], s0[sel]};

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic request(input logic [1:0] img);
    boot_req = 1'b1; boot_image = img;
    step();
    boot_req = 1'b0; boot_image = 2'b00;
  endtask

  // Follows a command from the first ss-low sample until ss rises; optionally
  // raises boot_req(11) and spi_busy at sample inj to show both are ignored.
  task automatic capture(input int inj, output logic [7:0] b, output int low, output int rises);
    logic prev = 1'b0;
    b = 8'h00; low = 0; rises = 0;
    while (m_ss === 1'b0 && low < 200) begin
      if (m_sck === 1'b1 && prev === 1'b0) begin
        b = {b[6:0], m_so}; rises++;
      end
      prev = m_sck;
      if (low == inj) begin boot_req = 1'b1; boot_image = 2'b11; spi_busy = 1'b1; end
      else begin boot_req = 1'b0; boot_image = 2'b00; end
      low++;
      step();
    end
    spi_busy = 1'b0;
  endtask

  task automatic test_reset();
    rst0 = 1'b0; rst1 = 1'b0;
    repeat (3) step();
    n_vec++;
    if ({ss[0], sck[0], grant[0], wbb[0], bsy[0], s1[0], s0[0]} !== 7'b1000001) begin
      n_err++;
      $display("FAIL reset_u0: got ss,sck,grant,boot,busy,s1s0=%b want 1000001",
               {ss[0], sck[0], grant[0], wbb[0], bsy[0], s1[0], s0[0]});
    end
    n_vec++;
    if ({ss[1], sck[1], grant[1], wbb[1], bsy[1], s1[1], s0[1]} !== 7'b1000001) begin
      n_err++;
      $display("FAIL reset_u1: got %b want 1000001",
               {ss[1], sck[1], grant[1], wbb[1], bsy[1], s1[1], s0[1]});
    end
  endtask

  task automatic test_nominal();
    logic [7:0] b; int low, rises, bad;
    sel = 0; rst0 = 1'b1; step();
    request(2'b10);
    n_vec++;
    if ({m_bsy, m_grant, m_ss, m_img} !== 5'b10110) begin
      n_err++; $display("FAIL nom_wait: busy,grant,ss,img=%b want 10110", {m_bsy, m_grant, m_ss, m_img});
    end
    step();
    n_vec++;
    if ({m_grant, m_ss, m_sck} !== 3'b100) begin
      n_err++; $display("FAIL nom_ss_low: grant,ss,sck=%b want 100", {m_grant, m_ss, m_sck});
    end
    capture(-1, b, low, rises);
    n_vec++;
    if (b !== 8'hAB || low != 32 || rises != 8) begin
      n_err++; $display("FAIL nom_cmd: byte=%h low=%0d rises=%0d want ab/32/8", b, low, rises);
    end
    n_vec++;
    if ({m_ss, m_sck, m_so, m_grant, m_wbb} !== 5'b10010) begin
      n_err++; $display("FAIL nom_cmd_end: ss,sck,so,grant,boot=%b want 10010", {m_ss, m_sck, m_so, m_grant, m_wbb});
    end
    bad = 0;
    repeat (9) begin step(); if (m_wbb !== 1'b0 || m_ss !== 1'b1 || m_grant !== 1'b1) bad++; end
    n_vec++;
    if (bad != 0) begin n_err++; $display("FAIL nom_tres: %0d bad cycles want 0", bad); end
    bad = 0;
    repeat (4) begin step(); if (m_wbb !== 1'b1 || m_img !== 2'b10) bad++; end
    n_vec++;
    if (bad != 0) begin n_err++; $display("FAIL nom_boot_hold: %0d bad cycles want 0", bad); end
    step();
    n_vec++;
    if ({m_wbb, m_bsy, m_grant, m_ss, m_img} !== 6'b011110) begin
      n_err++; $display("FAIL nom_halt: boot,busy,grant,ss,img=%b want 011110", {m_wbb, m_bsy, m_grant, m_ss, m_img});
    end
    request(2'b00);
    repeat (3) step();
    n_vec++;
    if ({m_wbb, m_bsy, m_ss, m_img} !== 5'b01110) begin
      n_err++; $display("FAIL halt_sticky: boot,busy,ss,img=%b want 01110", {m_wbb, m_bsy, m_ss, m_img});
    end
  endtask

  task automatic test_bus_held();
    int bad = 0;
    sel = 0; rst0 = 1'b0; step(); rst0 = 1'b1;
    spi_busy = 1'b1;
    request(2'b11);
    repeat (50) begin if (m_grant !== 1'b0 || m_ss !== 1'b1 || m_bsy !== 1'b1) bad++; step(); end
    n_vec++;
    if (bad != 0) begin n_err++; $display("FAIL bus_held: %0d cycles with grant/ss changed want 0", bad); end
    spi_busy = 1'b0;
    n_vec++;
    if ({m_grant, m_ss} !== 2'b01) begin
      n_err++; $display("FAIL bus_release_early: grant,ss=%b want 01", {m_grant, m_ss});
    end
    step();
    n_vec++;
    if ({m_grant, m_ss, m_img} !== 4'b1011) begin
      n_err++; $display("FAIL bus_release: grant,ss,img=%b want 1011", {m_grant, m_ss, m_img});
    end
  endtask

  task automatic test_ignored_req();
    logic [7:0] b; int low, rises;
    sel = 0; rst0 = 1'b0; step(); rst0 = 1'b1;
    request(2'b10);
    step();
    capture(4, b, low, rises);
    n_vec++;
    if (b !== 8'hAB || low != 32 || m_img !== 2'b10) begin
      n_err++; $display("FAIL ignored_req: byte=%h low=%0d img=%b want ab/32/10", b, low, m_img);
    end
  endtask

  task automatic test_reset_mid_cmd();
    logic [7:0] b; int low, rises;
    sel = 0; rst0 = 1'b0; step(); rst0 = 1'b1;
    request(2'b10);
    step();
    repeat (16) step();
    n_vec++;
    if ({m_ss, m_grant} !== 2'b01) begin
      n_err++; $display("FAIL mid_cmd_pre: ss,grant=%b want 01", {m_ss, m_grant});
    end
    rst0 = 1'b0;
    step();
    rst0 = 1'b1;
    n_vec++;
    if ({m_ss, m_grant, m_sck, m_so, m_bsy, m_img} !== 7'b1000001) begin
      n_err++; $display("FAIL mid_cmd_reset: ss,grant,sck,so,busy,img=%b want 1000001",
                        {m_ss, m_grant, m_sck, m_so, m_bsy, m_img});
    end
    request(2'b01);
    step();
    capture(-1, b, low, rises);
    n_vec++;
    if (b !== 8'hAB || low != 32 || rises != 8) begin
      n_err++; $display("FAIL mid_cmd_rerun: byte=%h low=%0d rises=%0d want ab/32/8", b, low, rises);
    end
  endtask

  task automatic test_min_params();
    logic [7:0] b; int low, rises;
    rst0 = 1'b0; sel = 1; rst1 = 1'b1; step();
    request(2'b10);
    step();
    n_vec++;
    if ({m_grant, m_ss, m_sck} !== 3'b100) begin
      n_err++; $display("FAIL min_start: grant,ss,sck=%b want 100", {m_grant, m_ss, m_sck});
    end
    capture(-1, b, low, rises);
    n_vec++;
    if (b !== 8'hAB || low != 16 || rises != 8) begin
      n_err++; $display("FAIL min_cmd: byte=%h low=%0d rises=%0d want ab/16/8", b, low, rises);
    end
    n_vec++;
    if (m_wbb !== 1'b0) begin n_err++; $display("FAIL min_tres: boot=%b want 0", m_wbb); end
    step();
    n_vec++;
    if ({m_wbb, m_img} !== 3'b110) begin
      n_err++; $display("FAIL min_boot: boot,img=%b want 110", {m_wbb, m_img});
    end
    step();
    n_vec++;
    if ({m_wbb, m_bsy, m_grant, m_ss} !== 4'b0111) begin
      n_err++; $display("FAIL min_halt: boot,busy,grant,ss=%b want 0111", {m_wbb, m_bsy, m_grant, m_ss});
    end
  endtask

  initial begin
    test_reset();
    test_nominal();
    test_bus_held();
    test_ignored_req();
    test_reset_mid_cmd();
    test_min_params();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
